// File: rtl/bitty_prefetch.sv
// Instruction prefetcher: one outstanding ROM fetch feeding a small in-order queue.
// A redirect flushes the queue and discards any response still in flight.
module bitty_prefetch #(
    parameter int             XLEN     = 32,
    parameter int             DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_ce_o,
    output logic [XLEN-1:0]            rom_addr_o,
    input  logic                       rom_valid_i,
    input  logic [XLEN-1:0]            rom_data_i,
    input  logic                       branch_flag_i,
    input  logic [XLEN-1:0]            branch_addr_i,
    output logic                       inst_valid_o,
    output logic [XLEN-1:0]            inst_o,
    output logic [XLEN-1:0]            pc_o,
    input  logic                       inst_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [XLEN-1:0]   inst_mem_q [DEPTH];
    logic [XLEN-1:0]   pc_mem_q   [DEPTH];

    logic              head_valid_s;
    logic              pop_s;
    logic              push_s;
    logic              issue_s;
    logic              in_wait_s;
    logic              can_issue_s;
    logic [CW:0]       occ_s;

    // Occupancy counts the in-flight fetch so a response always has a free slot.
    assign head_valid_s = !rst && (count_q != '0);
    assign pop_s        = head_valid_s && inst_ready_i;
    assign in_wait_s    = (state_q == ST_WAIT);
    assign occ_s        = (CW+1)'(count_q) + (CW+1)'(in_wait_s) - (CW+1)'(pop_s);
    assign can_issue_s  = (state_q == ST_IDLE) || (in_wait_s && rom_valid_i);
    assign issue_s      = !rst && !branch_flag_i && can_issue_s && (occ_s < (CW+1)'(DEPTH));
    assign push_s       = !rst && in_wait_s && rom_valid_i && !branch_flag_i;

    assign rom_ce_o     = issue_s;
    assign rom_addr_o   = fetch_pc_q;
    assign inst_valid_o = head_valid_s;
    assign inst_o       = head_valid_s ? inst_mem_q[rd_ptr_q] : '0;
    assign pc_o         = head_valid_s ? pc_mem_q[rd_ptr_q] : '0;
    assign count_o      = rst ? '0 : count_q;

    // Next-state computation for the fetch FSM and queue pointers.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (branch_flag_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            fetch_pc_d = {branch_addr_i[XLEN-1:2], 2'b00};
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT: state_d = rom_valid_i ? ST_IDLE : ST_KILL;
                ST_KILL: state_d = rom_valid_i ? ST_IDLE : ST_KILL;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            fetch_pc_d = issue_s ? (fetch_pc_q + XLEN'(4)) : fetch_pc_q;
            req_pc_d   = issue_s ? fetch_pc_q : req_pc_q;
            wr_ptr_d   = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
            rd_ptr_d   = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
            count_d    = count_q + CW'(push_s) - CW'(pop_s);
            case (state_q)
                ST_IDLE: state_d = issue_s ? ST_WAIT : ST_IDLE;
                ST_WAIT: state_d = (rom_valid_i && !issue_s) ? ST_IDLE : ST_WAIT;
                ST_KILL: state_d = rom_valid_i ? ST_IDLE : ST_KILL;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; entries are only read while counted valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            inst_mem_q[wr_ptr_q] <= rom_data_i;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

endmodule
